// File: rtl/read_memory_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one read-only
// memory slave among several four-phase read masters.
module read_memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_OF_CHANNELS = 4,
  localparam int GW =
    (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic [NUMBER_OF_CHANNELS*ADDRESS_WIDTH-1:0] channelAddress,
  input  logic [NUMBER_OF_CHANNELS-1:0] channelReadEnabled,
  output logic [NUMBER_OF_CHANNELS*DATA_WIDTH-1:0] channelDataIn,
  output logic [NUMBER_OF_CHANNELS-1:0] channelFunctionComplete,
  output logic [ADDRESS_WIDTH-1:0] memoryAddress,
  output logic memoryReadEnabled,
  input  logic [DATA_WIDTH-1:0] memoryDataIn,
  input  logic memoryFunctionComplete,
  output logic [GW-1:0] grantedChannel,
  output logic busy
);

  localparam int N = NUMBER_OF_CHANNELS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_n;
  logic [GW-1:0] grant_q, grant_n;
  logic [GW-1:0] ptr_q, ptr_n;
  logic [GW-1:0] pick;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_n;
  logic mre_q, mre_n;
  logic [N-1:0] done_q, done_n;
  logic [N*DATA_WIDTH-1:0] data_q;
  logic load;
  logic found;
  int idx;

  // first eligible requester at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && channelReadEnabled[idx]
          && !done_q[idx]) begin
        found = 1'b1;
        pick = GW'(idx);
      end
    end
  end

  // next state and next values of the registered outputs
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    ptr_n = ptr_q;
    addr_n = addr_q;
    mre_n = mre_q;
    done_n = done_q;
    load = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = pick;
          addr_n = channelAddress[
            int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          mre_n = 1'b1;
          state_n = REQUEST;
        end
      end
      REQUEST: begin
        if (memoryFunctionComplete) begin
          load = 1'b1;
          done_n[grant_q] = 1'b1;
          mre_n = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!memoryFunctionComplete
            && !channelReadEnabled[grant_q]) begin
          done_n = '0;
          ptr_n = (int'(grant_q) == N - 1)
            ? '0 : grant_q + 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and control registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      mre_q <= 1'b0;
      done_q <= '0;
    end else begin
      state <= state_n;
      grant_q <= grant_n;
      ptr_q <= ptr_n;
      addr_q <= addr_n;
      mre_q <= mre_n;
      done_q <= done_n;
    end
  end

  // per-channel read data, only the granted slice is written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH]
        <= memoryDataIn;
    end
  end

  assign channelDataIn = data_q;
  assign channelFunctionComplete = done_q;
  assign memoryAddress = addr_q;
  assign memoryReadEnabled = mre_q;
  assign grantedChannel = grant_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_read_memory_arbiter.sv
// Randomised bench for read_memory_arbiter with a
// transaction-level round-robin model and memory slave.
module tb_read_memory_arbiter;

  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N*AW-1:0] channelAddress;
  logic [N-1:0] channelReadEnabled;
  logic [N*DW-1:0] channelDataIn;
  logic [N-1:0] channelFunctionComplete;
  logic [AW-1:0] memoryAddress;
  logic memoryReadEnabled;
  logic [DW-1:0] memoryDataIn;
  logic memoryFunctionComplete;
  logic [GW-1:0] grantedChannel;
  logic busy;

  read_memory_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUMBER_OF_CHANNELS(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .channelAddress(channelAddress),
    .channelReadEnabled(channelReadEnabled),
    .channelDataIn(channelDataIn),
    .channelFunctionComplete(channelFunctionComplete),
    .memoryAddress(memoryAddress),
    .memoryReadEnabled(memoryReadEnabled),
    .memoryDataIn(memoryDataIn),
    .memoryFunctionComplete(memoryFunctionComplete),
    .grantedChannel(grantedChannel),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [N-1:0] want, viol, inflight, prev_fc, cand;
  logic [AW-1:0] next_addr [N];
  logic [DW-1:0] exp_data [N];
  logic [AW-1:0] gaddr, a1;
  logic [DW-1:0] fix_val;
  int mptr, cur_g, mcnt, hcnt, lat, hold, n;
  bit rnd, mem_fix, mem_off, prev_mre, was_idle;
  int gq[$];

  task automatic check_eq(string tag, logic [63:0] got,
                          logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic logic [DW-1:0] word_of(logic [AW-1:0] a);
    return mem_fix ? fix_val : a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic int rr(int p, logic [N-1:0] c);
    for (int k = 0; k < N; k++)
      if (c[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic observe();
    logic rose, exp_rose;
    int g;
    rose = memoryReadEnabled && !prev_mre;
    exp_rose = was_idle && (cand != '0);
    check_eq("grant_rise", rose, exp_rose);
    if (rose && exp_rose) begin
      g = rr(mptr, cand);
      gaddr = channelAddress[g*AW +: AW];
      check_eq("grant_chan", grantedChannel, g);
      check_eq("mem_addr", memoryAddress, gaddr);
      cur_g = g;
      mptr = (g + 1) % N;
      gq.push_back(g);
    end
    for (int i = 0; i < N; i++)
      if (channelFunctionComplete[i] && !prev_fc[i]) begin
        check_eq("done_chan", i, cur_g);
        exp_data[i] = word_of(gaddr);
      end
    check_eq("done_onehot",
             $countones(channelFunctionComplete) <= 1, 1);
    for (int i = 0; i < N; i++)
      check_eq("data_hold", channelDataIn[i*DW +: DW],
               exp_data[i]);
  endtask

  task automatic drive();
    if (!mem_off) begin
      if (memoryReadEnabled && !memoryFunctionComplete) begin
        if (mcnt <= 0) begin
          memoryFunctionComplete = 1'b1;
          memoryDataIn = word_of(memoryAddress);
        end else mcnt--;
      end else if (!memoryReadEnabled
                   && memoryFunctionComplete) begin
        if (hcnt <= 0) begin
          memoryFunctionComplete = 1'b0;
          memoryDataIn = $urandom;
        end else hcnt--;
      end else if (!memoryReadEnabled) begin
        mcnt = rnd ? int'($urandom_range(0, 4)) : lat;
        hcnt = rnd ? int'($urandom_range(0, 2)) : hold;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (prev_fc[i] && !channelFunctionComplete[i])
        inflight[i] = 1'b0;
      if (channelReadEnabled[i] && channelFunctionComplete[i]) begin
        channelReadEnabled[i] = 1'b0;
      end else if (channelReadEnabled[i] && viol[i]
                   && memoryReadEnabled && grantedChannel == i
                   && !channelFunctionComplete[i]) begin
        channelReadEnabled[i] = 1'b0;
        viol[i] = 1'b0;
      end else if (!channelReadEnabled[i] && !inflight[i]
                   && !channelFunctionComplete[i] && want[i]) begin
        if (rnd) begin
          channelAddress[i*AW +: AW] = $urandom & ~32'd3;
          viol[i] = ($urandom_range(0, 7) == 0);
        end else begin
          channelAddress[i*AW +: AW] = next_addr[i];
          next_addr[i] = next_addr[i] + 32'h1000;
        end
        channelReadEnabled[i] = 1'b1;
        inflight[i] = 1'b1;
      end
    end
    prev_mre = memoryReadEnabled;
    prev_fc = channelFunctionComplete;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc > 40000) begin
      $display("FAIL cycle_budget: got %0d want <40000", cyc);
      $fatal(1, "cycle budget exceeded");
    end
    observe();
    drive();
    cand = channelReadEnabled & ~channelFunctionComplete;
    was_idle = !busy;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    channelReadEnabled = '0;
    channelAddress = '0;
    memoryFunctionComplete = 1'b0;
    memoryDataIn = '0;
    want = '0;
    viol = '0;
    inflight = '0;
    prev_fc = '0;
    prev_mre = 1'b0;
    cand = '0;
    was_idle = 1'b1;
    mptr = 0;
    cur_g = 0;
    mem_off = 1'b0;
    mcnt = lat;
    hcnt = hold;
    gq.delete();
    for (int i = 0; i < N; i++) exp_data[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_mre", memoryReadEnabled, 0);
    check_eq("rst_addr", memoryAddress, 0);
    check_eq("rst_done", channelFunctionComplete, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grantedChannel, 0);
    for (int i = 0; i < N; i++)
      check_eq("rst_data", channelDataIn[i*DW +: DW], 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_grants(int k, int lim);
    int c = 0;
    while (gq.size() < k && c < lim) begin
      step();
      c++;
    end
    check_eq("grant_count", gq.size(), k);
  endtask

  task automatic wait_done(int ch, int lim);
    int c = 0;
    while (!channelFunctionComplete[ch] && c < lim) begin
      step();
      c++;
    end
    check_eq("done_wait", channelFunctionComplete[ch], 1);
  endtask

  task automatic wait_idle(int lim);
    int c = 0;
    while ((busy || channelReadEnabled != '0 || inflight != '0
            || memoryFunctionComplete) && c < lim) begin
      step();
      c++;
    end
    check_eq("drain_idle", busy, 0);
  endtask

  initial begin
    rnd = 1'b0;
    mem_fix = 1'b0;
    fix_val = '0;
    lat = 3;
    hold = 0;
    for (int i = 0; i < N; i++)
      next_addr[i] = 32'h10000 * (i + 1);

    // single request on channel 2
    mem_fix = 1'b1;
    fix_val = 32'hDEADBEEF;
    do_reset();
    next_addr[2] = 32'h40;
    want = 4'b0100;
    wait_done(2, 30);
    check_eq("t1_addr", memoryAddress, 32'h40);
    check_eq("t1_done", channelFunctionComplete, 4'b0100);
    check_eq("t1_data", channelDataIn[2*DW +: DW], 32'hDEADBEEF);
    want = '0;
    wait_idle(20);
    mem_fix = 1'b0;

    // pointer now 3: channels 0 and 3 compete
    gq.delete();
    next_addr[0] = 32'h100;
    next_addr[3] = 32'h300;
    want = 4'b1001;
    wait_grants(2, 60);
    if (gq.size() >= 2) begin
      check_eq("wrap_first", gq[0], 3);
      check_eq("wrap_second", gq[1], 0);
    end
    want = '0;
    wait_idle(60);

    // all channels requesting continuously
    do_reset();
    want = 4'b1111;
    wait_grants(8, 200);
    if (gq.size() >= 8)
      for (int k = 0; k < 8; k++)
        check_eq("rr_seq", gq[k], k % N);
    want = '0;
    wait_idle(100);

    // memory completion held after the channel lets go
    hold = 3;
    want = 4'b0011;
    repeat (40) begin
      step();
      if (memoryFunctionComplete && !memoryReadEnabled)
        check_eq("rel_busy", busy, 1);
    end
    want = '0;
    wait_idle(60);
    hold = 0;

    // asynchronous reset in the middle of REQUEST
    lat = 6;
    want = 4'b1111;
    n = 0;
    while (!memoryReadEnabled && n < 20) begin
      step();
      n++;
    end
    check_eq("ar_req", memoryReadEnabled, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_mre", memoryReadEnabled, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_done", channelFunctionComplete, 0);
    lat = 2;
    do_reset();
    want = 4'b1111;
    wait_grants(1, 20);
    if (gq.size() >= 1) check_eq("ar_first", gq[0], 0);
    want = '0;
    wait_idle(100);

    // channel 1 abandons its request during REQUEST
    lat = 3;
    a1 = next_addr[1];
    viol[1] = 1'b1;
    want = 4'b0010;
    wait_done(1, 40);
    want = '0;
    wait_idle(40);
    check_eq("viol_data", channelDataIn[DW +: DW], word_of(a1));

    // stray memory completion while idle
    mem_off = 1'b1;
    memoryFunctionComplete = 1'b1;
    step();
    step();
    check_eq("stray_busy", busy, 0);
    check_eq("stray_done", channelFunctionComplete, 0);
    memoryFunctionComplete = 1'b0;
    mem_off = 1'b0;
    step();

    // randomised traffic
    rnd = 1'b1;
    repeat (500) begin
      if ($urandom_range(0, 9) == 0) want = N'($urandom);
      step();
    end
    want = '0;
    wait_idle(300);
    rnd = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
